// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - buffered 8N1 UART transmitter, 16 clken ticks per bit
//
// Ports:
//   clk_50m  - system clock, rising edge
//   rst      - asynchronous active-high reset
//   clken    - 16x baud tick, one clk_50m cycle wide
//   wr_en    - write strobe; din is enqueued when full=0
//   din      - byte to transmit
//   Tx       - serial line, idles high
//   busy     - frame on the line (START/DATA/STOP)
//   full     - FIFO holds DEPTH entries
//   empty    - FIFO holds no entries
//   tx_done  - one-cycle pulse when a stop bit completes
//   overflow - one-cycle pulse when a write arrives while full (byte dropped)
module uart_transmitter #(
  parameter int DEPTH = 4
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       clken,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       Tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       tx_done,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          pop;

  // Serializer state
  state_t     state;
  state_t     state_nxt;
  logic [3:0] sample;
  logic [3:0] sample_nxt;
  logic [2:0] bit_pos;
  logic [2:0] bit_pos_nxt;
  logic [7:0] shift_reg;
  logic [7:0] shift_nxt;
  logic       tx_nxt;
  logic       done_nxt;

  // full is registered, so a write on the same edge as a pop from a full
  // FIFO is still rejected.
  assign push = wr_en & ~full;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      full     <= (count_nxt == DEPTH_C);
      empty    <= (count_nxt == '0);
      overflow <= wr_en & full;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Next-state logic; everything is frozen while clken is low.
  always_comb begin
    state_nxt   = state;
    sample_nxt  = sample;
    bit_pos_nxt = bit_pos;
    shift_nxt   = shift_reg;
    tx_nxt      = Tx;
    done_nxt    = 1'b0;
    pop         = 1'b0;
    if (clken) begin
      case (state)
        IDLE: begin
          tx_nxt = 1'b1;
          if (count != '0) begin
            pop        = 1'b1;
            shift_nxt  = mem[rd_ptr];
            tx_nxt     = 1'b0;
            sample_nxt = 4'd0;
            state_nxt  = START;
          end
        end
        START: begin
          sample_nxt = sample + 4'd1;
          if (sample == 4'd15) begin
            tx_nxt      = shift_reg[0];
            bit_pos_nxt = 3'd0;
            sample_nxt  = 4'd0;
            state_nxt   = DATA;
          end
        end
        DATA: begin
          sample_nxt = sample + 4'd1;
          if (sample == 4'd15) begin
            sample_nxt = 4'd0;
            if (bit_pos == 3'd7) begin
              tx_nxt    = 1'b1;
              state_nxt = STOP;
            end else begin
              bit_pos_nxt = bit_pos + 3'd1;
              tx_nxt      = shift_reg[bit_pos_nxt];
            end
          end
        end
        STOP: begin
          sample_nxt = sample + 4'd1;
          if (sample == 4'd15) begin
            done_nxt   = 1'b1;
            sample_nxt = 4'd0;
            // Back-to-back frames: next start bit begins on this same edge.
            if (count != '0) begin
              pop       = 1'b1;
              shift_nxt = mem[rd_ptr];
              tx_nxt    = 1'b0;
              state_nxt = START;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          tx_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sample    <= 4'd0;
      bit_pos   <= 3'd0;
      shift_reg <= 8'd0;
      Tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sample    <= sample_nxt;
      bit_pos   <= bit_pos_nxt;
      shift_reg <= shift_nxt;
      Tx        <= tx_nxt;
      tx_done   <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - randomized self-checking bench for uart_transmitter
module tb_uart_transmitter;

  localparam int DEPTH = 4;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic       clken;
  logic       wr_en;
  logic [7:0] din;
  logic       Tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic       tx_done;
  logic       overflow;

  uart_transmitter #(.DEPTH(DEPTH)) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .clken    (clken),
    .wr_en    (wr_en),
    .din      (din),
    .Tx       (Tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .tx_done  (tx_done),
    .overflow (overflow)
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of accepted bytes plus a frame-level line view
  // (tick offset k since the start edge, 160 ticks per frame).
  logic [7:0] mq[$];
  bit         in_frame = 0;
  int         k = 0;
  logic [7:0] cur = 8'd0;
  int         frames_done = 0;
  int         accepted = 0;
  int         mode = 0;   // 0: clken always, N>0: one in N, -1: random
  int         cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic tick(input bit w, input logic [7:0] d);
    int  pre;
    bit  exp_done;
    bit  exp_ovf;
    bit  ce;
    cyc++;
    if (mode == 0)     ce = 1'b1;
    else if (mode > 0) ce = ((cyc % mode) == 0);
    else               ce = ($urandom_range(0, 2) == 0);
    clken = ce;
    wr_en = w;
    din   = d;
    @(posedge clk_50m);
    #1;
    pre      = mq.size();
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
    if (ce) begin
      if (in_frame) begin
        k++;
        if (k == 160) begin
          exp_done = 1'b1;
          frames_done++;
          if (pre != 0) begin
            cur = mq.pop_front();
            k   = 0;
          end else begin
            in_frame = 1'b0;
          end
        end
      end else if (pre != 0) begin
        cur      = mq.pop_front();
        in_frame = 1'b1;
        k        = 0;
      end
    end
    if (w) begin
      if (pre == DEPTH) exp_ovf = 1'b1;
      else begin
        mq.push_back(d);
        accepted++;
      end
    end
    check("tx", 32'(Tx), 32'(in_frame ? frame_bit(cur, k / 16) : 1'b1));
    check("busy", 32'(busy), 32'(in_frame));
    check("tx_done", 32'(tx_done), 32'(exp_done));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    wr_en = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (in_frame || mq.size() != 0); i++) tick(1'b0, 8'h00);
    check("drain_timeout", 32'(in_frame || mq.size() != 0), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    clken = 1'b0;
    wr_en = 1'b0;
    din   = 8'h00;
    #5;
    check("rst_tx", 32'(Tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk_50m);
    #1;
    rst = 1'b0;

    // Single byte
    mode = 0;
    tick(1'b1, 8'hA5);
    drain(400);
    check("single_frames", 32'(frames_done), 32'd1);

    // Back-to-back
    tick(1'b1, 8'h00);
    tick(1'b1, 8'hFF);
    drain(600);
    check("b2b_frames", 32'(frames_done), 32'd3);

    // Overflow burst
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 8'(8'h10 + i));
      if (i == 5) check("ovf_full5", 32'(full), 32'd1);
      if (i == 6) check("ovf_pulse6", 32'(overflow), 32'd1);
    end
    drain(1200);
    check("ovf_frames", 32'(frames_done), 32'd8);

    // Slow enable
    mode = 27;
    tick(1'b1, 8'h3C);
    drain(6000);

    // Random enable and writes
    mode = -1;
    for (int i = 0; i < 4000; i++) tick($urandom_range(0, 99) < 4, 8'($urandom));
    drain(4000);
    mode = 0;
    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 99) < 2, 8'($urandom));
    drain(1200);
    check("all_frames", 32'(frames_done), 32'(accepted));

    // Reset during data bit 3
    mode = 0;
    tick(1'b1, 8'hC3);
    tick(1'b1, 8'h99);
    for (int i = 0; i < 200 && !(in_frame && k == 70); i++) tick(1'b0, 8'h00);
    check("reach_bit3", 32'(in_frame && k == 70), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_tx", 32'(Tx), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    mq.delete();
    in_frame = 1'b0;
    k = 0;
    @(posedge clk_50m);
    #1;
    check("arst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    frames_done = 0;
    tick(1'b1, 8'h5A);
    drain(400);
    check("post_rst_frames", 32'(frames_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
